wordgen: RTL and testbench
==========================

WORDGEN -- requirements
Module: wordgen

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 100; clocks per serial bit (2 us at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 8; word-memory entries; power of two.
REQ-003 Clock: sysclk, input, 1 bit; 50 MHz system clock, rising edge.
REQ-004 Reset: rst_n, input, 1 bit; synchronous, active-low.
REQ-005 Switch inputs: sw1, sw2, sw3, sw4, input, 1 bit each; word bits, sw1 = MSB, sw4 = LSB; asynchronous.
REQ-006 write, input, 1 bit; capture/transmit request; asynchronous, level.
REQ-007 auto, input, 1 bit; 1 = replay stored words, 0 = manual; asynchronous.
REQ-008 out, output, 1 bit; registered serial line, idle high.

Function
REQ-009 Every asynchronous input SHALL pass through a 2-flop synchronizer; logic uses only synchronized copies.
REQ-010 Frame: start bit 0, 4 data bits MSB first (sw1..sw4), stop bit 1; each bit exactly BIT_PERIOD clocks.
REQ-011 Serializer FSM states IDLE -> START -> DATA (4 bits) -> STOP -> IDLE, or STOP -> START directly when another frame is pending; out = 1 in IDLE.
REQ-012 Write capture: synchronized write rising edge with auto=0 stores {sw1,sw2,sw3,sw4} at wr_ptr; wr_ptr increments modulo DEPTH; count saturates at DEPTH; when full, the oldest entry is overwritten.
REQ-013 Manual mode (auto=0): while write=1, frames repeat back-to-back; each frame samples the live switch word on entering START.
REQ-014 Auto mode (auto=1): write ignored; frames replay entries 0..count-1 in order, then wrap to 0; count=0 -> IDLE.
REQ-015 Start bit on out SHALL appear exactly 3 clocks after the write (or auto) rising edge at the pin: 2 sync + 1 output register.
REQ-016 An in-progress frame SHALL always complete (stop bit included) when write falls or auto toggles; the new mode applies at the next frame boundary.
REQ-017 Entering auto mode resets rd_ptr to 0.
REQ-018 A write edge coincident with the auto rising edge SHALL NOT be stored.

Reset
REQ-019 rst_n=0 at a clock edge: out=1, FSM=IDLE, wr_ptr=rd_ptr=count=0, bit and period counters 0, synchronizers cleared; memory contents are don't-care.
REQ-020 Reset mid-frame aborts the frame; out=1 from the next clock.

Configuration
REQ-021 Macro WORDGEN_PARITY_EN defined: an even-parity bit (XOR of the 4 data bits) is inserted between the last data bit and the stop bit; frame = 7 bits. Undefined: no parity state; frame = 6 bits.

Structure
REQ-022 Package wordgen_pkg: FSM state enum, DATA_BITS=4, FRAME_BITS (6 or 7 per the macro), word typedef logic [3:0].
REQ-023 One sub-module, wordgen_serializer: FSM plus bit and period counters; input word and load strobe; output out and frame-done flag. The top level holds the synchronizers, the memory and the mode control.

Verification
REQ-024 Reset: rst_n=0 for 5 clocks with write=1 -> out=1 throughout; count=0 after release.
REQ-025 Manual: sw=1000, write rises -> out=0 at clock +3 for 100 clocks, then 1,0,0,0, then stop 1; frames repeat while write=1; out=1 after write falls and the current frame completes.
REQ-026 Capture: three write pulses with sw=1000, 1110, 1111, then auto=1 -> frames carry 1000, 1110, 1111, 1000 in sequence.
REQ-027 Wrap: 9 write pulses with words 0..8 (DEPTH=8), then auto=1 -> first replayed word is 8 (entry 0 overwritten), then 1..7.
REQ-028 Mid-frame: write falls during data bit 2 -> frame completes with its stop bit, then out stays 1; rst_n=0 during DATA -> out=1 on the next clock.
REQ-029 With WORDGEN_PARITY_EN: sw=1110 -> parity bit 1 between the last data bit and the stop bit; frame length 700 clocks.

Source files
------------

// File: rtl/wordgen_pkg.sv
// wordgen_pkg -- shared types and constants for the wordgen serial word generator.
//   state_t     : serializer FSM states (ST_PARITY exists only with WORDGEN_PARITY_EN)
//   word_t      : 4-bit switch word, bit 3 = sw1 (MSB), bit 0 = sw4 (LSB)
//   DATA_BITS   : data bits per frame
//   FRAME_BITS  : start + data (+ parity) + stop
//   even_parity : XOR of the data bits
// Build option: define WORDGEN_PARITY_EN to insert an even-parity bit before the stop bit.
package wordgen_pkg;

  localparam int DATA_BITS = 4;

`ifdef WORDGEN_PARITY_EN
  localparam int FRAME_BITS = 7;
`else
  localparam int FRAME_BITS = 6;
`endif

  typedef logic [DATA_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef WORDGEN_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/wordgen_serializer.sv
// wordgen_serializer -- frame FSM with bit and period counters.
//   sysclk       : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   i_load       : a frame is available (level); taken when idle or at stop-bit end
//   i_word       : word to send, captured when the frame is taken
//   o_idle       : FSM is in IDLE
//   o_frame_done : last clock of the stop bit
//   o_out        : registered serial line, idle high
// Build option: WORDGEN_PARITY_EN adds the parity state.
module wordgen_serializer
  import wordgen_pkg::*;
#(
  parameter int BIT_PERIOD = 100
) (
  input  logic  sysclk,
  input  logic  rst_n,
  input  logic  i_load,
  input  word_t i_word,
  output logic  o_idle,
  output logic  o_frame_done,
  output logic  o_out
);

  localparam logic [15:0] LAST_TICK = 16'(BIT_PERIOD - 1);
`ifdef WORDGEN_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
`else
  localparam state_t AFTER_DATA = ST_STOP;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_period;
  logic [15:0] w_next_period;
  logic [1:0]  r_bit;
  logic [1:0]  w_next_bit;
  word_t       r_word;
  logic        r_out;
  logic        w_next_out;
  logic        w_period_end;
  logic        w_frame_done;
  logic        w_accept;

  assign w_period_end = (r_period == LAST_TICK);
  assign w_accept     = i_load & ((r_state == ST_IDLE) | w_frame_done);
  assign o_idle       = (r_state == ST_IDLE);
  assign o_frame_done = w_frame_done;
  assign o_out        = r_out;

  // Next-state, counter and next-output logic; out is computed from the next state so it is registered.
  always_comb begin
    w_next_state  = r_state;
    w_next_period = r_period + 16'd1;
    w_next_bit    = r_bit;
    w_frame_done  = 1'b0;
    w_next_out    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_next_period = 16'd0;
        if (i_load) begin
          w_next_state = ST_START;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_period_end) begin
          w_next_period = 16'd0;
          w_next_bit    = 2'd0;
          w_next_state  = ST_DATA;
        end else begin
          w_next_state  = ST_START;
        end
      end
      ST_DATA: begin
        if (w_period_end) begin
          w_next_period = 16'd0;
          if (r_bit == 2'd3) begin
            w_next_state = AFTER_DATA;
          end else begin
            w_next_bit   = r_bit + 2'd1;
          end
        end else begin
          w_next_state = ST_DATA;
        end
      end
`ifdef WORDGEN_PARITY_EN
      ST_PARITY: begin
        if (w_period_end) begin
          w_next_period = 16'd0;
          w_next_state  = ST_STOP;
        end else begin
          w_next_state  = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (w_period_end) begin
          w_frame_done  = 1'b1;
          w_next_period = 16'd0;
          // Back-to-back frames skip IDLE so there is no gap after the stop bit.
          if (i_load) begin
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_STOP;
        end
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_next_period = 16'd0;
        w_next_bit    = 2'd0;
      end
    endcase

    case (w_next_state)
      ST_IDLE:   w_next_out = 1'b1;
      ST_START:  w_next_out = 1'b0;
      // MSB first: data bit 0 is word bit 3, so the index is the bit count inverted.
      ST_DATA:   w_next_out = r_word[~w_next_bit];
`ifdef WORDGEN_PARITY_EN
      ST_PARITY: w_next_out = even_parity(r_word);
`endif
      ST_STOP:   w_next_out = 1'b1;
      default:   w_next_out = 1'b1;
    endcase
  end

  // State, counters, captured word and output register.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_period <= 16'd0;
      r_bit    <= 2'd0;
      r_word   <= 4'd0;
      r_out    <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_period <= w_next_period;
      r_bit    <= w_next_bit;
      r_out    <= w_next_out;
      if (w_accept) begin
        r_word <= i_word;
      end
    end
  end

endmodule

// File: rtl/wordgen.sv
// wordgen -- switch-word serial generator with a small replay memory.
//   sysclk         : 50 MHz system clock, rising edge
//   rst_n          : synchronous active-low reset
//   sw1..sw4       : word bits (sw1 = MSB), asynchronous
//   write          : capture / transmit request, asynchronous level
//   auto           : 1 = replay stored words, 0 = manual, asynchronous
//   out            : registered serial line, idle high
// Parameters: BIT_PERIOD (clocks per bit, 2..65535), DEPTH (memory entries, power of two >= 2).
// Build option: WORDGEN_PARITY_EN inserts an even-parity bit before the stop bit.
module wordgen
  import wordgen_pkg::*;
#(
  parameter int BIT_PERIOD = 100,
  parameter int DEPTH      = 8
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic sw4,
  input  logic write,
  input  logic auto,
  output logic out
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [5:0]       r_meta;
  logic [5:0]       r_sync;
  logic             r_write_d;
  logic             r_auto_d;
  word_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  word_t            w_sw;
  logic             w_write;
  logic             w_auto;
  logic             w_write_rise;
  logic             w_auto_rise;
  logic             w_capture;
  logic [PTR_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_rd_next;
  logic             w_load;
  word_t            w_word;
  logic             w_idle;
  logic             w_frame_done;
  logic             w_accept;

  assign w_sw         = r_sync[3:0];
  assign w_write      = r_sync[4];
  assign w_auto       = r_sync[5];
  assign w_write_rise = w_write & ~r_write_d;
  assign w_auto_rise  = w_auto & ~r_auto_d;
  // A write edge arriving with (or during) auto is never stored.
  assign w_capture    = w_write_rise & ~w_auto;
  assign w_accept     = w_load & (w_idle | w_frame_done);

  // Two-flop synchronizers for every asynchronous input, plus edge-detect history.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_meta    <= 6'd0;
      r_sync    <= 6'd0;
      r_write_d <= 1'b0;
      r_auto_d  <= 1'b0;
    end else begin
      r_meta    <= {auto, write, sw1, sw2, sw3, sw4};
      r_sync    <= r_meta;
      r_write_d <= w_write;
      r_auto_d  <= w_auto;
    end
  end

  // Frame source selection: live switches in manual mode, memory replay in auto mode.
  always_comb begin
    // The auto edge restarts replay at entry 0 in the same clock the first frame is taken.
    if (w_auto_rise) begin
      w_rd_idx = PTR_ZERO;
    end else begin
      w_rd_idx = r_rd_ptr;
    end
    if (({1'b0, w_rd_idx} + CNT_ONE) == r_count) begin
      w_rd_next = PTR_ZERO;
    end else begin
      w_rd_next = w_rd_idx + PTR_ONE;
    end
    if (w_auto) begin
      w_load = (r_count != CNT_ZERO);
      w_word = r_mem[w_rd_idx];
    end else begin
      w_load = w_write;
      w_word = w_sw;
    end
  end

  // Word memory; contents need no reset.
  always_ff @(posedge sysclk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= w_sw;
    end
  end

  // Write pointer, fill count and replay pointer.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_count != CNT_FULL) begin
          r_count <= r_count + CNT_ONE;
        end
      end
      if (w_accept && w_auto) begin
        r_rd_ptr <= w_rd_next;
      end else if (w_auto_rise) begin
        r_rd_ptr <= PTR_ZERO;
      end
    end
  end

  wordgen_serializer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_ser (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_word      (w_word),
    .o_idle      (w_idle),
    .o_frame_done(w_frame_done),
    .o_out       (out)
  );

endmodule

// File: tb/tb_wordgen.sv
`timescale 1ns/1ps
module tb_wordgen;

  localparam int BP = 100;
`ifdef WORDGEN_PARITY_EN
  localparam int EXP_FRAME = 7;
`else
  localparam int EXP_FRAME = 6;
`endif
  localparam int FRAME_CLK = EXP_FRAME * BP;

  logic sysclk = 1'b0;
  logic rst_n, sw1, sw2, sw3, sw4, write, auto;
  logic out;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #10 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  wordgen #(.BIT_PERIOD(BP), .DEPTH(8)) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4),
    .write(write), .auto(auto), .out(out)
  );

  typedef struct {
    logic [3:0] sw;
    logic [3:0] exp_w;
  } vec_t;
  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] w);
    {sw1, sw2, sw3, sw4} = w;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at the first clock of a start bit; samples mid-bit, ends mid stop bit.
  // drop >= 0 releases write and auto after sampling that data bit.
  task automatic rx_check(input string nm, input logic [3:0] ew, input int drop);
    logic [3:0] w;
    logic s0, s1;
    w = 4'd0;
    tick(BP/2);
    s0 = out;
    for (int i = 0; i < 4; i++) begin
      tick(BP);
      w = {w[2:0], out};
      if (i == drop) begin
        write = 1'b0;
        auto  = 1'b0;
      end
    end
`ifdef WORDGEN_PARITY_EN
    tick(BP);
    chk({nm, "_par"}, int'(out), int'(^ew));
`endif
    tick(BP);
    s1 = out;
    chk({nm, "_startbit"}, int'(s0), 0);
    chk({nm, "_word"}, int'(w), int'(ew));
    chk({nm, "_stopbit"}, int'(s1), 1);
  endtask

  task automatic wait_start(input string nm);
    int n;
    n = 0;
    while (out !== 1'b0 && n < 2 * FRAME_CLK) begin
      tick(1);
      n++;
    end
    chk({nm, "_found"}, int'(out === 1'b0), 1);
  endtask

  task automatic expect_idle(input string nm, input int n);
    int z;
    z = 0;
    repeat (n) begin
      tick(1);
      if (out !== 1'b1) z++;
    end
    chk(nm, z, 0);
  endtask

  task automatic pulse(input logic [3:0] w);
    set_sw(w);
    write = 1'b1;
    tick(4);
    write = 1'b0;
    tick(FRAME_CLK + 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int s1;
    vecs[0] = '{4'b1000, 4'b1000};
    vecs[1] = '{4'b0001, 4'b0001};
    vecs[2] = '{4'b0101, 4'b0101};
    vecs[3] = '{4'b1111, 4'b1111};
    vecs[4] = '{4'b0000, 4'b0000};
    vecs[5] = '{4'b1110, 4'b1110};

    // Reset held with write high: line stays idle, nothing stored.
    rst_n = 1'b0; write = 1'b1; auto = 1'b0; set_sw(4'b1000);
    repeat (5) begin
      tick(1);
      chk("rst_hold", int'(out), 1);
    end
    rst_n = 1'b1; write = 1'b0;
    tick(1);
    chk("rst_release", int'(out), 1);
    auto = 1'b1;
    expect_idle("rst_count0", 3 * BP);
    auto = 1'b0;
    tick(5);

    // Manual single frames from the vector table, with 3-clock start latency.
    foreach (vecs[k]) begin
      set_sw(vecs[k].sw);
      write = 1'b1;
      tick(2);
      chk("lat_pre", int'(out), 1);
      tick(1);
      chk("lat_start", int'(out), 0);
      rx_check("vec", vecs[k].exp_w, 3);
      expect_idle("vec_idle", 2 * BP);
    end

    // Back-to-back frames while write is held; second frame samples new switches.
    set_sw(4'b1000);
    write = 1'b1;
    tick(3);
    s1 = cyc;
    rx_check("rep1", 4'b1000, -1);
    set_sw(4'b0101);
    wait_start("rep2");
    chk("rep_len", cyc - s1, FRAME_CLK);
    rx_check("rep2", 4'b0101, 0);
    expect_idle("rep_idle", 2 * BP);

    // Write falls during data bit 2: frame still completes.
    set_sw(4'b1010);
    write = 1'b1;
    tick(3);
    rx_check("mid", 4'b1010, 1);
    expect_idle("mid_idle", 2 * BP);

    // Reset during a data bit aborts the frame on the next clock.
    set_sw(4'b0000);
    write = 1'b1;
    tick(3);
    tick(BP/2 + BP);
    chk("rst_pre", int'(out), 0);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid", int'(out), 1);
    write = 1'b0;
    tick(4);
    rst_n = 1'b1;
    expect_idle("rst_after", 2 * BP);

    // Capture three words, then replay them in auto mode.
    pulse(4'b1000);
    pulse(4'b1110);
    pulse(4'b1111);
    auto = 1'b1;
    tick(2);
    chk("auto_pre", int'(out), 1);
    tick(1);
    chk("auto_start", int'(out), 0);
    rx_check("cap0", 4'b1000, -1);
    wait_start("cap1");
    rx_check("cap1", 4'b1110, -1);
    wait_start("cap2");
    rx_check("cap2", 4'b1111, -1);
    wait_start("cap3");
    rx_check("cap3", 4'b1000, 0);
    expect_idle("cap_idle", 2 * BP);

    // Coincident write/auto edge is not stored; then overfill the memory.
    do_reset();
    write = 1'b1; auto = 1'b1;
    expect_idle("coinc_idle", 3 * BP);
    write = 1'b0; auto = 1'b0;
    tick(5);
    for (int i = 0; i < 9; i++) pulse(4'(i));
    auto = 1'b1;
    tick(3);
    chk("wrap_start", int'(out), 0);
    rx_check("wrap0", 4'd8, -1);
    for (int i = 1; i < 8; i++) begin
      wait_start("wrap");
      rx_check("wrap", 4'(i), -1);
    end
    wait_start("wrap_again");
    rx_check("wrap_again", 4'd8, 0);
    expect_idle("wrap_idle", 2 * BP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
